// File: rtl/freq_gen_pkg.sv
// Shared types and interface widths for the freq_gen pulse-train generator.
package freq_gen_pkg;

    localparam int unsigned FREQ_W = 16;
    localparam int unsigned WIN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/freq_gen_counter.sv
// Free-running up-counter with synchronous clear (clear wins over enable).
module freq_gen_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    // Count register: clear has priority, otherwise count when enabled.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= {WIDTH{1'b0}};
        end else if (clr_i) begin
            cnt_q <= {WIDTH{1'b0}};
        end else if (en_i) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/freq_gen.sv
// Window-based pulse generator: f pulses per WINDOW_CYC cycles via a phase accumulator.
// Optional pulse counter output enabled by defining FREQ_GEN_PULSE_CNT_EN.
module freq_gen
    import freq_gen_pkg::*;
#(
    parameter int WINDOW_CYC = 100000,
    parameter int OUT_DATA   = 100
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [FREQ_W-1:0]   freq_i,
    input  logic [WIN_W-1:0]    windows_i,
    input  logic [OUT_DATA-1:0] mask_i,
    output logic [OUT_DATA-1:0] value_o,
    output logic                busy_o,
    output logic                done_o
`ifdef FREQ_GEN_PULSE_CNT_EN
    ,
    output logic [31:0]         pulse_cnt_o
`endif
);

    localparam int CNT_W = $clog2(WINDOW_CYC);
    localparam int ACC_W = $clog2(WINDOW_CYC) + 1;
    localparam logic [ACC_W-1:0] WIN_A  = ACC_W'(WINDOW_CYC);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WINDOW_CYC - 1);

    state_e              state_q;
    logic [ACC_W-1:0]    acc_q, f_q;
    logic [WIN_W-1:0]    win_q, idx_q;
    logic [OUT_DATA-1:0] mask_q, value_q;
    logic                busy_q, done_q;

    logic [CNT_W-1:0]    w_s;
    logic [ACC_W-1:0]    sum_s, acc_d, f_clamp_s;
    logic                pulse_s, run_s, start_s, wrap_s, last_s, cnt_clr_s;

    // Accumulator step, window wrap and last-window detection.
    always_comb begin
        run_s     = (state_q == ST_RUN);
        start_s   = (state_q == ST_IDLE) && start_i;
        wrap_s    = run_s && (w_s == W_LAST);
        cnt_clr_s = start_s || wrap_s;
        last_s    = wrap_s && (win_q != WIN_W'(0)) && (idx_q == (win_q - WIN_W'(1)));
        sum_s     = acc_q + f_q;
        pulse_s   = 1'b0;
        acc_d     = sum_s;
        if (sum_s >= WIN_A) begin
            pulse_s = 1'b1;
            acc_d   = sum_s - WIN_A;
        end else begin
            pulse_s = 1'b0;
            acc_d   = sum_s;
        end
        if (32'(freq_i) > 32'(WINDOW_CYC)) begin
            f_clamp_s = WIN_A;
        end else begin
            f_clamp_s = ACC_W'(freq_i);
        end
    end

    freq_gen_counter #(.WIDTH(CNT_W)) u_win_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (cnt_clr_s),
        .en_i   (run_s),
        .cnt_o  (w_s)
    );

    // Control FSM with registered value/busy/done outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            acc_q   <= {ACC_W{1'b0}};
            f_q     <= {ACC_W{1'b0}};
            win_q   <= {WIN_W{1'b0}};
            idx_q   <= {WIN_W{1'b0}};
            mask_q  <= {OUT_DATA{1'b0}};
            value_q <= {OUT_DATA{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    value_q <= {OUT_DATA{1'b0}};
                    done_q  <= 1'b0;
                    if (start_i) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        f_q     <= f_clamp_s;
                        win_q   <= windows_i;
                        mask_q  <= mask_i;
                        acc_q   <= {ACC_W{1'b0}};
                        idx_q   <= {WIN_W{1'b0}};
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop_i) begin
                        // Abort drops any pulse produced in this cycle.
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        value_q <= {OUT_DATA{1'b0}};
                    end else begin
                        acc_q   <= acc_d;
                        value_q <= pulse_s ? mask_q : {OUT_DATA{1'b0}};
                        if (wrap_s) begin
                            idx_q <= idx_q + WIN_W'(1);
                        end else begin
                            idx_q <= idx_q;
                        end
                        if (last_s) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    value_q <= {OUT_DATA{1'b0}};
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    value_q <= {OUT_DATA{1'b0}};
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FREQ_GEN_PULSE_CNT_EN
    logic [31:0] pcnt_q;

    // Saturating count of emitted pulses, cleared on each accepted start.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pcnt_q <= 32'd0;
        end else if (start_s) begin
            pcnt_q <= 32'd0;
        end else if (run_s && !stop_i && pulse_s && (pcnt_q != 32'hFFFF_FFFF)) begin
            pcnt_q <= pcnt_q + 32'd1;
        end else begin
            pcnt_q <= pcnt_q;
        end
    end

    assign pulse_cnt_o = pcnt_q;
`endif

    assign value_o = value_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_freq_gen.sv
// Directed self-checking bench for freq_gen (WINDOW_CYC=100, OUT_DATA=8).
module tb_freq_gen;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        start_i;
    logic        stop_i;
    logic [15:0] freq_i;
    logic [7:0]  windows_i;
    logic [7:0]  mask_i;
    logic [7:0]  value_o;
    logic        busy_o;
    logic        done_o;
`ifdef FREQ_GEN_PULSE_CNT_EN
    logic [31:0] pulse_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    freq_gen #(.WINDOW_CYC(100), .OUT_DATA(8)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .freq_i    (freq_i),
        .windows_i (windows_i),
        .mask_i    (mask_i),
        .value_o   (value_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
`ifdef FREQ_GEN_PULSE_CNT_EN
        ,
        .pulse_cnt_o (pulse_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench in the first RUN cycle (w=0).
    task automatic start_run(input logic [15:0] f, input logic [7:0] n, input logic [7:0] m);
        freq_i    = f;
        windows_i = n;
        mask_i    = m;
        start_i   = 1'b1;
        step();
        start_i   = 1'b0;
    endtask

    initial begin
        int cnt;
        rstn_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        freq_i = 16'd0; windows_i = 8'd0; mask_i = 8'h00;
        #12;
        chk("rst_value", 32'(value_o), 32'h0);
        chk("rst_busy",  32'(busy_o),  32'h0);
        chk("rst_done",  32'(done_o),  32'h0);
        rstn_i = 1'b1;
        step();
        step();

        // f=4, one window: pulses visible at w=25,50,75 and in the DONE cycle.
        start_run(16'd4, 8'd1, 8'hFF);
        for (int k = 0; k < 100; k++) begin
            chk("t1_value", 32'(value_o), (k == 25 || k == 50 || k == 75) ? 32'hFF : 32'h0);
            chk("t1_busy",  32'(busy_o),  32'h1);
            chk("t1_done",  32'(done_o),  32'h0);
            step();
        end
        chk("t1_value_last", 32'(value_o), 32'hFF);
        chk("t1_done_pulse", 32'(done_o),  32'h1);
        chk("t1_busy_done",  32'(busy_o),  32'h0);
        step();
        chk("t1_done_clr",   32'(done_o),  32'h0);
        chk("t1_value_idle", 32'(value_o), 32'h0);
        step();

        // f=0, two windows: silent, busy for 200 cycles, one done.
        start_run(16'd0, 8'd2, 8'hFF);
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (value_o != 8'h00 || busy_o != 1'b1 || done_o != 1'b0) cnt++;
            step();
        end
        chk("t2_run_cycles_bad", 32'(cnt), 32'h0);
        chk("t2_done_pulse", 32'(done_o), 32'h1);
        chk("t2_busy_done",  32'(busy_o), 32'h0);
        step();
        chk("t2_done_clr",   32'(done_o), 32'h0);
        step();

        // f=500 clamps to 100: value high for 100 consecutive cycles.
        start_run(16'd500, 8'd1, 8'h05);
        chk("t3_value_c0", 32'(value_o), 32'h0);
        step();
        cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            if (value_o == 8'h05) cnt++;
            step();
        end
        chk("t3_high_count", 32'(cnt), 32'd100);
        chk("t3_value_after", 32'(value_o), 32'h0);
        step();

        // f=3 continuous: pulses visible at w=34,67 and the next window's w=0.
        start_run(16'd3, 8'd0, 8'h3C);
        for (int c = 0; c <= 1033; c++) begin
            chk("t4_value", 32'(value_o),
                (c > 0 && ((c % 100) == 34 || (c % 100) == 67 || (c % 100) == 0)) ? 32'h3C : 32'h0);
            chk("t4_busy", 32'(busy_o), 32'h1);
            if (c == 1033) stop_i = 1'b1;
            step();
        end
        stop_i = 1'b0;
        chk("t4_stop_busy",  32'(busy_o),  32'h0);
        chk("t4_stop_value", 32'(value_o), 32'h0);
        chk("t4_stop_done",  32'(done_o),  32'h0);
        step();
        chk("t4_idle_done",  32'(done_o),  32'h0);
        chk("t4_idle_value", 32'(value_o), 32'h0);

        // stop_i on the final cycle of the last window wins over done.
        start_run(16'd100, 8'd1, 8'h81);
        for (int k = 0; k < 99; k++) step();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        chk("t5_busy",  32'(busy_o),  32'h0);
        chk("t5_done",  32'(done_o),  32'h0);
        chk("t5_value", 32'(value_o), 32'h0);
        step();
        chk("t5_done_late", 32'(done_o), 32'h0);

        // Asynchronous reset at RUN cycle 37.
        start_run(16'd100, 8'd1, 8'hAA);
        for (int k = 0; k < 37; k++) step();
        chk("t6_value_pre", 32'(value_o), 32'hAA);
        rstn_i = 1'b0;
        #1;
        chk("t6_value_rst", 32'(value_o), 32'h0);
        chk("t6_busy_rst",  32'(busy_o),  32'h0);
        chk("t6_done_rst",  32'(done_o),  32'h0);
        #1;
        rstn_i = 1'b1;
        cnt = 0;
        for (int k = 0; k < 110; k++) begin
            step();
            if (busy_o != 1'b0 || done_o != 1'b0 || value_o != 8'h00) cnt++;
        end
        chk("t6_idle_after_rst", 32'(cnt), 32'h0);

        // start_i held and inputs changed during RUN/DONE have no effect.
        start_run(16'd2, 8'd1, 8'h0F);
        start_i = 1'b1; freq_i = 16'd100; mask_i = 8'hF0; windows_i = 8'd5;
        for (int k = 0; k < 100; k++) begin
            chk("t7_value", 32'(value_o), (k == 50) ? 32'h0F : 32'h0);
            chk("t7_busy",  32'(busy_o),  32'h1);
            step();
        end
        chk("t7_done",  32'(done_o),  32'h1);
        chk("t7_value_last", 32'(value_o), 32'h0F);
        step();
        start_i = 1'b0;
        chk("t7_idle_busy", 32'(busy_o), 32'h0);
        chk("t7_idle_done", 32'(done_o), 32'h0);
        step();
        chk("t7_no_restart", 32'(busy_o), 32'h0);

`ifdef FREQ_GEN_PULSE_CNT_EN
        // f=7 over three windows emits 21 pulses; next start clears.
        start_run(16'd7, 8'd3, 8'h01);
        for (int k = 0; k < 300; k++) step();
        chk("t8_done", 32'(done_o), 32'h1);
        chk("t8_cnt",  pulse_cnt_o, 32'd21);
        step();
        step();
        chk("t8_cnt_hold", pulse_cnt_o, 32'd21);
        start_run(16'd7, 8'd1, 8'h01);
        chk("t8_cnt_clr", pulse_cnt_o, 32'd0);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
